// File: rtl/led_matrix_pkg.sv
// Shared register map, CTRL bit positions and reset constants for the LED matrix controller.
package led_matrix_pkg;

    localparam logic [2:0] ADDR_BACK0  = 3'd0;
    localparam logic [2:0] ADDR_BACK1  = 3'd1;
    localparam logic [2:0] ADDR_BACK2  = 3'd2;
    localparam logic [2:0] ADDR_BACK3  = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;
    localparam logic [2:0] ADDR_BLINK  = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_BLINK_EN = 1;
    localparam int unsigned CTRL_COMMIT   = 2;

    localparam int unsigned BLINK_RESET   = 30;
    localparam int unsigned FRAME_COUNT_W = 6;

endpackage

// File: rtl/led_matrix_if.sv
// Byte-wide CPU register bus shared by the LED matrix controller and its host.
interface led_matrix_if;

    logic [2:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_we,
        output bus_re,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_we,
        input  bus_re,
        output bus_rdata
    );

endinterface

// File: rtl/led_frame_timer.sv
// Free-running scan-frame timer: one-cycle frame_tick on the last clock of each frame,
// plus a wrapping count of completed frames.
module led_frame_timer
    import led_matrix_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = 4096
) (
    input  logic                     clk12MHz,
    input  logic                     reset,
    output logic                     frame_tick,
    output logic [FRAME_COUNT_W-1:0] frame_count
);

    localparam int unsigned TimerW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(FRAME_CYCLES - 1);

    logic [TimerW-1:0]        timer_q, timer_d;
    logic [FRAME_COUNT_W-1:0] count_q, count_d;

    assign frame_tick  = (timer_q == TimerLast);
    assign frame_count = count_q;

    always_comb begin
        timer_d = timer_q + 1'b1;
        count_d = count_q;
        if (frame_tick) begin
            timer_d = '0;
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            timer_q <= '0;
            count_q <= '0;
        end else begin
            timer_q <= timer_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_matrix_ctrl.sv
// Double-buffered 4x8 LED image controller: bus-written back buffer, tear-free commit at
// frame boundaries, global enable and frame-based blink driving the column scanner.
module led_matrix_ctrl
    import led_matrix_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = 4096,
    parameter int unsigned BLINK_W      = 8
) (
    input  logic        clk12MHz,
    input  logic        reset,
    led_matrix_if.slave bus,
    output logic [7:0]  leds1,
    output logic [7:0]  leds2,
    output logic [7:0]  leds3,
    output logic [7:0]  leds4,
    output logic        frame_irq
);

    logic                     frame_tick;
    logic [FRAME_COUNT_W-1:0] frame_count;

    logic [3:0][7:0]    back_q, back_d;
    logic [3:0][7:0]    front_q, front_d;
    logic [3:0][7:0]    leds_q, leds_d;
    logic               en_q, en_d;
    logic               blink_en_q, blink_en_d;
    logic               pending_q, pending_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               irq_q, irq_d;

    logic               commit_wr;
    logic               swap;
    logic               show;
    logic [BLINK_W-1:0] blink_last;
    logic [7:0]         rd_mux;

    led_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_frame_timer (
        .clk12MHz    (clk12MHz),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .frame_count (frame_count)
    );

    // A commit written on the tick cycle defers the swap to the following tick.
    assign commit_wr  = bus.bus_we && (bus.bus_addr == ADDR_CTRL) && bus.bus_wdata[CTRL_COMMIT];
    assign swap       = frame_tick && pending_q && !commit_wr;
    assign show       = en_q && (!blink_en_q || phase_q);
    assign blink_last = (blink_q == '0) ? '0 : blink_q - 1'b1;

    always_comb begin
        rd_mux = 8'h00;
        case (bus.bus_addr)
            ADDR_BACK0, ADDR_BACK1, ADDR_BACK2, ADDR_BACK3: rd_mux = back_q[bus.bus_addr[1:0]];
            ADDR_CTRL:   rd_mux = {5'b0, pending_q, blink_en_q, en_q};
            ADDR_BLINK:  rd_mux = 8'(blink_q);
            ADDR_STATUS: rd_mux = {frame_count, phase_q, pending_q};
            default:     rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        back_d      = back_q;
        front_d     = front_q;
        en_d        = en_q;
        blink_en_d  = blink_en_q;
        pending_d   = pending_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        rdata_d     = rdata_q;
        irq_d       = swap;

        // Swap copies the registered back buffer, so a same-cycle BACK write lands after it.
        if (swap) begin
            front_d   = back_q;
            pending_d = 1'b0;
        end
        if (commit_wr) begin
            pending_d = 1'b1;
        end

        if (frame_tick) begin
            if (blink_cnt_q >= blink_last) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        if (bus.bus_we) begin
            case (bus.bus_addr)
                ADDR_BACK0, ADDR_BACK1, ADDR_BACK2, ADDR_BACK3: begin
                    back_d[bus.bus_addr[1:0]] = bus.bus_wdata;
                end
                ADDR_CTRL: begin
                    en_d       = bus.bus_wdata[CTRL_EN];
                    blink_en_d = bus.bus_wdata[CTRL_BLINK_EN];
                end
                ADDR_BLINK: begin
                    blink_d     = BLINK_W'(bus.bus_wdata);
                    blink_cnt_d = '0;
                    phase_d     = 1'b1;
                end
                default: ;
            endcase
        end

        for (int i = 0; i < 4; i++) begin
            leds_d[i] = show ? front_q[i] : 8'h00;
        end

        if (bus.bus_re) begin
            rdata_d = rd_mux;
        end
    end

    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            back_q      <= '0;
            front_q     <= '0;
            leds_q      <= '0;
            en_q        <= 1'b0;
            blink_en_q  <= 1'b0;
            pending_q   <= 1'b0;
            blink_q     <= BLINK_W'(BLINK_RESET);
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            rdata_q     <= 8'h00;
            irq_q       <= 1'b0;
        end else begin
            back_q      <= back_d;
            front_q     <= front_d;
            leds_q      <= leds_d;
            en_q        <= en_d;
            blink_en_q  <= blink_en_d;
            pending_q   <= pending_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    assign leds1         = leds_q[0];
    assign leds2         = leds_q[1];
    assign leds3         = leds_q[2];
    assign leds4         = leds_q[3];
    assign frame_irq     = irq_q;
    assign bus.bus_rdata = rdata_q;

endmodule

// File: tb/tb_led_matrix_ctrl.sv
// Scoreboard bench for led_matrix_ctrl: a frame-level reference model predicts leds,
// read data and commit interrupts; a negedge monitor compares against the DUT.
module tb_led_matrix_ctrl;

    localparam int F = 4096;

    logic clk12MHz;
    logic reset;
    logic [7:0] leds1, leds2, leds3, leds4;
    logic frame_irq;

    led_matrix_if bus ();

    led_matrix_ctrl #(
        .FRAME_CYCLES (F),
        .BLINK_W      (8)
    ) dut (
        .clk12MHz  (clk12MHz),
        .reset     (reset),
        .bus       (bus),
        .leds1     (leds1),
        .leds2     (leds2),
        .leds3     (leds3),
        .leds4     (leds4),
        .frame_irq (frame_irq)
    );

    initial clk12MHz = 1'b0;
    always #5 clk12MHz = ~clk12MHz;

    int npass  = 0;
    int ntotal = 0;

    // Reference model state
    logic [7:0] m_back [4];
    logic [7:0] m_front[4];
    bit         m_en, m_ben, m_pend;
    int         m_blink;
    int         nticks, anchor, t, cyc;
    logic [31:0] m_leds;
    bit         m_rvalid;
    bit         started = 1'b0;
    logic [7:0] rd_q[$];
    int         irq_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Phase is on for the first half-period after reset or a BLINK write, then alternates.
    function automatic bit phase_now();
        int eff;
        eff = (m_blink == 0) ? 1 : m_blink;
        return (((nticks - anchor) / eff) % 2) == 0;
    endfunction

    function automatic logic [7:0] read_model(input logic [2:0] a);
        logic [5:0] fc;
        fc = 6'(nticks % 64);
        case (a)
            3'd0, 3'd1, 3'd2, 3'd3: return m_back[a[1:0]];
            3'd4: return {5'b0, m_pend, m_ben, m_en};
            3'd5: return 8'(m_blink);
            3'd6: return {fc, phase_now(), m_pend};
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk12MHz) begin
        bit tick, commit_wr, swap, show;
        cyc++;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_back[i]  = 8'h00;
                m_front[i] = 8'h00;
            end
            m_en = 0; m_ben = 0; m_pend = 0; m_blink = 30;
            nticks = 0; anchor = 0; t = 0;
            m_leds = 32'h0; m_rvalid = 0;
            rd_q.delete();
            irq_q.delete();
            started = 1'b1;
        end else begin
            tick = (t % F) == F - 1;
            show = m_en && (!m_ben || phase_now());
            m_leds = show ? {m_front[3], m_front[2], m_front[1], m_front[0]} : 32'h0;
            m_rvalid = bus.bus_re;
            if (bus.bus_re) rd_q.push_back(read_model(bus.bus_addr));
            commit_wr = bus.bus_we && bus.bus_addr == 3'd4 && bus.bus_wdata[2];
            swap = tick && m_pend && !commit_wr;
            if (swap) begin
                for (int i = 0; i < 4; i++) m_front[i] = m_back[i];
                m_pend = 0;
                irq_q.push_back(cyc);
            end
            if (tick) nticks++;
            if (bus.bus_we) begin
                case (bus.bus_addr)
                    3'd0, 3'd1, 3'd2, 3'd3: m_back[bus.bus_addr[1:0]] = bus.bus_wdata;
                    3'd4: begin
                        m_en  = bus.bus_wdata[0];
                        m_ben = bus.bus_wdata[1];
                        if (bus.bus_wdata[2]) m_pend = 1;
                    end
                    3'd5: begin
                        m_blink = int'(bus.bus_wdata);
                        anchor  = nticks;
                    end
                    default: ;
                endcase
            end
            t++;
        end
    end

    always @(negedge clk12MHz) begin
        int exp_cyc;
        if (started) begin
            check("leds", {leds4, leds3, leds2, leds1}, m_leds);
            if (m_rvalid) check("rdata", 32'(bus.bus_rdata), 32'(rd_q.pop_front()));
            if (frame_irq === 1'b1) begin
                exp_cyc = (irq_q.size() > 0) ? irq_q.pop_front() : -1;
                check("frame_irq_cycle", cyc, exp_cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk12MHz);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.bus_addr = a; bus.bus_wdata = d; bus.bus_we = 1'b1;
        step();
        bus.bus_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        bus.bus_addr = a; bus.bus_re = 1'b1;
        step();
        bus.bus_re = 1'b0;
    endtask

    task automatic wrrd(input logic [2:0] a, input logic [7:0] d);
        bus.bus_addr = a; bus.bus_wdata = d; bus.bus_we = 1'b1; bus.bus_re = 1'b1;
        step();
        bus.bus_we = 1'b0; bus.bus_re = 1'b0;
    endtask

    // Bounded: at most one frame plus one cycle.
    task automatic wait_timer(input int v);
        for (int i = 0; i <= F && (t % F) != v; i++) step();
    endtask

    initial begin
        #(10 * 120000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] a;
        logic [7:0] d;
        reset = 1'b1;
        bus.bus_addr = 3'd0; bus.bus_wdata = 8'h00; bus.bus_we = 1'b0; bus.bus_re = 1'b0;
        idle(3);
        reset = 1'b0;
        check("reset_rdata", 32'(bus.bus_rdata), 32'h0);
        check("reset_irq", 32'(frame_irq), 32'h0);

        // 1: image loaded and enabled, but no commit
        wr(3'd0, 8'h01); wr(3'd1, 8'h02); wr(3'd2, 8'h04); wr(3'd3, 8'h08);
        wr(3'd4, 8'h01);
        idle(2 * F);
        check("t1_leds_dark", {leds4, leds3, leds2, leds1}, 32'h0);
        rd(3'd6);
        check("t1_status_pend", 32'(bus.bus_rdata[0]), 32'h0);

        // 2: commit mid-frame, swap at the next tick
        wait_timer(100);
        wr(3'd4, 8'h05);
        rd(3'd6);
        check("t2_pend_before", 32'(bus.bus_rdata[0]), 32'h1);
        wait_timer(1);
        check("t2_leds_after", {leds4, leds3, leds2, leds1}, 32'h08040201);
        rd(3'd6);
        check("t2_pend_after", 32'(bus.bus_rdata[0]), 32'h0);

        // 3: BACK write on the tick cycle with commit pending
        wr(3'd4, 8'h05);
        wait_timer(F - 1);
        wr(3'd0, 8'hAA);
        wait_timer(10);
        check("t3_leds1_old", 32'(leds1), 32'h01);
        wr(3'd4, 8'h05);
        wait_timer(F - 1);
        idle(3);
        check("t3_leds1_new", 32'(leds1), 32'hAA);

        // 4: blink every 2 frames, then BLINK=0 toggles every frame
        wr(3'd5, 8'd2);
        wr(3'd4, 8'h07);
        idle(4 * F);
        wr(3'd5, 8'd0);
        idle(2 * F);

        // 5: reset mid-frame with a commit pending
        wr(3'd0, 8'h5A);
        wr(3'd4, 8'h05);
        wait_timer(2000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("t5_leds_zero", {leds4, leds3, leds2, leds1}, 32'h0);
        rd(3'd4);
        check("t5_ctrl_clear", 32'(bus.bus_rdata), 32'h0);
        idle(F + 4);

        // 6: read of the unused address, then read-during-write of CTRL
        wr(3'd0, 8'h11); wr(3'd1, 8'h22); wr(3'd2, 8'h33); wr(3'd3, 8'h44);
        wr(3'd4, 8'h05);
        wait_timer(F - 1);
        idle(3);
        check("t6_leds_on", {leds4, leds3, leds2, leds1}, 32'h44332211);
        rd(3'd7);
        check("t6_addr7", 32'(bus.bus_rdata), 32'h0);
        wrrd(3'd4, 8'h00);
        check("t6_ctrl_old", 32'(bus.bus_rdata), 32'h01);
        idle(2);
        check("t6_leds_off", {leds4, leds3, leds2, leds1}, 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 2 * F; c++) begin
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            if (a == 3'd5) d = 8'($urandom_range(0, 3));
            if (a == 3'd4 && (t % F) == F - 1 && m_pend) d[2] = 1'b0;
            bus.bus_addr  = a;
            bus.bus_wdata = d;
            bus.bus_we    = ($urandom_range(0, 31) == 0);
            bus.bus_re    = ($urandom_range(0, 7) == 0);
            step();
        end
        bus.bus_we = 1'b0; bus.bus_re = 1'b0;
        idle(4);

        check("irq_queue_drained", 32'(irq_q.size()), 32'h0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
